// File: rtl/lcd_driver_if.sv
// lcd_driver_if: byte handshake between core and the character LCD driver.
//   bus_lcd  [7:0] : byte from core
//   send_lcd       : byte valid, taken only while busy_lcd is low
//   busy_lcd       : driver is initialising, transferring or waiting
// master = core side, slave = lcd_driver side.
interface lcd_driver_if;
   logic [7:0] bus_lcd;
   logic       send_lcd;
   logic       busy_lcd;

   modport master (output bus_lcd, output send_lcd, input busy_lcd);
   modport slave  (input bus_lcd, input send_lcd, output busy_lcd);
endinterface

// File: rtl/lcd_driver.sv
// lcd_driver: HD44780 16x2 driver in 8-bit mode. Runs the power-on init,
// then turns a byte stream from core into character writes and a few
// display commands, tracking the cursor and wrapping lines itself.
// Ports:
//   clk_core             : system clock, rising edge
//   reset                : asynchronous, active-low
//   core_if (slave)      : bus_lcd / send_lcd / busy_lcd handshake
//   lcd_rs, lcd_rw, lcd_e: panel control (lcd_rw tied low, write-only)
//   lcd_data [7:0]       : DB7..DB0
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_PWR_WAIT | power-on delay after reset
// S_INIT     | one cycle, loads the first init command
// S_IDLE     | ready for a byte from core
// S_SETUP    | rs/data driven, e low, before the strobe
// S_E_HIGH   | enable strobe high
// S_EXEC     | e low, rs/data held, panel executes the command
// S_WRAP     | setup phase of the automatic line-wrap instruction
module lcd_driver #(
   parameter int POWERON_CYC = 750000,
   parameter int CMD_CYC     = 2000,
   parameter int CLR_CYC     = 82000,
   parameter int SETUP_CYC   = 2,
   parameter int E_CYC       = 12
) (
   input  logic         clk_core,
   input  logic         reset,
   lcd_driver_if.slave  core_if,
   output logic         lcd_rs,
   output logic         lcd_rw,
   output logic         lcd_e,
   output logic [7:0]   lcd_data
);
   localparam int CNT_W = $clog2(POWERON_CYC + CLR_CYC + CMD_CYC + 1);
   // PWR_WAIT plus the single INIT cycle together span POWERON_CYC cycles.
   localparam logic [CNT_W-1:0] PWR_LOAD   = CNT_W'(POWERON_CYC - 2);
   localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] E_LOAD     = CNT_W'(E_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(CLR_CYC - 1);

   typedef enum logic [2:0] {
      S_PWR_WAIT, S_INIT, S_IDLE, S_SETUP, S_E_HIGH, S_EXEC, S_WRAP
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [7:0]       data_nx, byte_q, byte_nx;
   logic             rs_nx;
   logic [4:0]       col, col_nx;
   logic             line, line_nx;
   logic             pend, pend_nx;
   logic             init_act, init_act_nx;
   logic [2:0]       idx, idx_nx;
   logic             drop_q, drop_nx;
   logic             cnt_zero, long_wait;
   logic [7:0]       line_cmd;

   function automatic logic [7:0] init_cmd(input logic [2:0] i);
      case (i)
         3'd3:    init_cmd = 8'h0C;
         3'd4:    init_cmd = 8'h01;
         3'd5:    init_cmd = 8'h06;
         default: init_cmd = 8'h38;
      endcase
   endfunction

   assign cnt_zero  = (cnt == '0);
   // Clear and home need the long execution wait.
   assign long_wait = !lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02);
   // Set DDRAM address to the start of the other line.
   assign line_cmd  = {1'b1, ~line, 6'd0};

   assign lcd_e            = (state == S_E_HIGH);
   assign lcd_rw           = 1'b0;
   assign core_if.busy_lcd = (state != S_IDLE) || drop_q;

   always_ff @(posedge clk_core or negedge reset) begin
      if (!reset) begin
         state    <= S_PWR_WAIT;
         cnt      <= PWR_LOAD;
         lcd_data <= 8'h00;
         lcd_rs   <= 1'b0;
         byte_q   <= 8'h00;
         col      <= 5'd0;
         line     <= 1'b0;
         pend     <= 1'b0;
         init_act <= 1'b1;
         idx      <= 3'd0;
         drop_q   <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         lcd_data <= data_nx;
         lcd_rs   <= rs_nx;
         byte_q   <= byte_nx;
         col      <= col_nx;
         line     <= line_nx;
         pend     <= pend_nx;
         init_act <= init_act_nx;
         idx      <= idx_nx;
         drop_q   <= drop_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      data_nx     = lcd_data;
      rs_nx       = lcd_rs;
      byte_nx     = byte_q;
      col_nx      = col;
      line_nx     = line;
      pend_nx     = pend;
      init_act_nx = init_act;
      idx_nx      = idx;
      drop_nx     = 1'b0;
      case (state)
         S_PWR_WAIT: begin
            if (cnt_zero) state_nx = S_INIT;
            else          cnt_nx   = cnt - 1'b1;
         end
         S_INIT: begin
            idx_nx   = 3'd0;
            data_nx  = init_cmd(3'd0);
            rs_nx    = 1'b0;
            cnt_nx   = SETUP_LOAD;
            state_nx = S_SETUP;
         end
         S_IDLE: begin
            if (core_if.send_lcd && !drop_q) begin
               cnt_nx   = SETUP_LOAD;
               state_nx = S_SETUP;
               rs_nx    = 1'b0;
               if (core_if.bus_lcd >= 8'h20) begin
                  if (col == 5'd16) begin
                     // Wrap first; the byte itself follows from EXEC.
                     data_nx  = line_cmd;
                     line_nx  = ~line;
                     col_nx   = 5'd1;
                     byte_nx  = core_if.bus_lcd;
                     pend_nx  = 1'b1;
                     state_nx = S_WRAP;
                  end else begin
                     data_nx = core_if.bus_lcd;
                     rs_nx   = 1'b1;
                     col_nx  = col + 5'd1;
                  end
               end else if (core_if.bus_lcd == 8'h0A) begin
                  data_nx = line_cmd;
                  line_nx = ~line;
                  col_nx  = 5'd0;
               end else if (core_if.bus_lcd == 8'h0C || core_if.bus_lcd == 8'h0D) begin
                  data_nx = (core_if.bus_lcd == 8'h0C) ? 8'h01 : 8'h02;
                  line_nx = 1'b0;
                  col_nx  = 5'd0;
               end else begin
                  // Unsupported control byte: one busy cycle, panel untouched.
                  rs_nx    = lcd_rs;
                  cnt_nx   = cnt;
                  state_nx = S_IDLE;
                  drop_nx  = 1'b1;
               end
            end
         end
         S_SETUP, S_WRAP: begin
            if (cnt_zero) begin
               cnt_nx   = E_LOAD;
               state_nx = S_E_HIGH;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         S_E_HIGH: begin
            if (cnt_zero) begin
               cnt_nx   = long_wait ? CLR_LOAD : CMD_LOAD;
               state_nx = S_EXEC;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         S_EXEC: begin
            if (!cnt_zero) begin
               cnt_nx = cnt - 1'b1;
            end else if (pend) begin
               pend_nx  = 1'b0;
               data_nx  = byte_q;
               rs_nx    = 1'b1;
               cnt_nx   = SETUP_LOAD;
               state_nx = S_SETUP;
            end else if (init_act && idx != 3'd5) begin
               idx_nx   = idx + 3'd1;
               data_nx  = init_cmd(idx + 3'd1);
               cnt_nx   = SETUP_LOAD;
               state_nx = S_SETUP;
            end else begin
               init_act_nx = 1'b0;
               state_nx    = S_IDLE;
            end
         end
         default: state_nx = S_PWR_WAIT;
      endcase
   end
endmodule

// File: tb/tb_lcd_driver.sv
module tb_lcd_driver;
   localparam int P = 20, CMD = 5, CLR = 10, S = 2, E = 3;
   localparam int INIT_CYC = P + 6 * (S + E) + 5 * CMD + CLR;

   logic       clk_core = 1'b0;
   logic       reset = 1'b0;
   logic       lcd_rs, lcd_rw, lcd_e;
   logic [7:0] lcd_data;

   lcd_driver_if bus_if();

   lcd_driver #(.POWERON_CYC(P), .CMD_CYC(CMD), .CLR_CYC(CLR),
                .SETUP_CYC(S), .E_CYC(E)) dut (
      .clk_core (clk_core),
      .reset    (reset),
      .core_if  (bus_if.slave),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_e    (lcd_e),
      .lcd_data (lcd_data)
   );

   always #5 clk_core = ~clk_core;

   int total = 0;
   int bad = 0;

   // Pulses seen on the panel: {rs, data} latched on each rising lcd_e.
   logic [8:0] got_q[$];
   logic [8:0] exp_q[$];
   int         stab_err = 0;
   int         width_err = 0;
   logic       e_prev = 1'b0;
   logic [8:0] rd_prev = 9'd0;
   int         e_len = 0;

   always @(negedge clk_core) begin
      if (!reset) begin
         e_prev = 1'b0;
         e_len  = 0;
      end else begin
         if (lcd_e && !e_prev) begin
            got_q.push_back({lcd_rs, lcd_data});
            e_len = 0;
         end
         if ((lcd_e || e_prev) && {lcd_rs, lcd_data} !== rd_prev) stab_err++;
         if (lcd_e) e_len++;
         if (!lcd_e && e_prev && e_len != E) width_err++;
         e_prev = lcd_e;
      end
      rd_prev = {lcd_rs, lcd_data};
   end

   // Reference model: cursor position and expected panel traffic per byte.
   int m_col = 0;
   int m_line = 0;
   int exp_busy, exp_erise;

   task automatic model_byte(input logic [7:0] b);
      exp_q.delete();
      exp_busy  = 0;
      exp_erise = S + 1;
      if (b >= 8'h20) begin
         if (m_col == 16) begin
            exp_q.push_back({1'b0, 8'h80 + (m_line == 1 ? 8'h00 : 8'h40)});
            m_line   = 1 - m_line;
            m_col    = 0;
            exp_busy += S + E + CMD;
         end
         exp_q.push_back({1'b1, b});
         m_col++;
         exp_busy += S + E + CMD;
      end else if (b == 8'h0A) begin
         exp_q.push_back({1'b0, 8'h80 + (m_line == 1 ? 8'h00 : 8'h40)});
         m_line   = 1 - m_line;
         m_col    = 0;
         exp_busy = S + E + CMD;
      end else if (b == 8'h0C || b == 8'h0D) begin
         exp_q.push_back({1'b0, (b == 8'h0C) ? 8'h01 : 8'h02});
         m_line   = 0;
         m_col    = 0;
         exp_busy = S + E + CLR;
      end else begin
         exp_busy  = 1;
         exp_erise = -1;
      end
   endtask

   // Sends one byte (optionally poking 0x43 while busy) and measures the
   // busy length and the cycle of the first lcd_e rise after acceptance.
   task automatic send_byte(input logic [7:0] b, input bit inject,
                            output int busy_n, output int e_rise);
      int guard = 0;
      while (bus_if.busy_lcd !== 1'b0 && guard < 5000) begin
         @(posedge clk_core); #1;
         guard++;
      end
      if (guard >= 5000) begin
         total++; bad++;
         $display("FAIL idle_wait busy_lcd never fell before byte %h", b);
      end
      got_q.delete();
      bus_if.bus_lcd  = b;
      bus_if.send_lcd = 1'b1;
      @(posedge clk_core); #1;
      bus_if.send_lcd = 1'b0;
      busy_n = 0;
      e_rise = -1;
      while (bus_if.busy_lcd === 1'b1 && busy_n < 500) begin
         busy_n++;
         if (lcd_e === 1'b1 && e_rise < 0) e_rise = busy_n;
         if (inject && busy_n == 3) begin
            bus_if.bus_lcd  = 8'h43;
            bus_if.send_lcd = 1'b1;
         end else begin
            bus_if.send_lcd = 1'b0;
         end
         @(posedge clk_core); #1;
      end
      bus_if.send_lcd = 1'b0;
   endtask

   task automatic test_init_seq(input string nm);
      int n = 0;
      logic [8:0] init_exp[6];
      init_exp = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006};
      m_col  = 0;
      m_line = 0;
      got_q.delete();
      reset = 1'b1;
      do begin
         @(posedge clk_core); #1;
         n++;
      end while (bus_if.busy_lcd !== 1'b0 && n < 3000);
      total++;
      if (n != INIT_CYC) begin
         bad++;
         $display("FAIL %s init_busy_fall got=%0d exp=%0d", nm, n, INIT_CYC);
      end
      total++;
      if (got_q.size() != 6) begin
         bad++;
         $display("FAIL %s init_pulse_count got=%0d exp=6", nm, got_q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            total++;
            if (got_q[i] !== init_exp[i]) begin
               bad++;
               $display("FAIL %s init_cmd%0d got=%h exp=%h", nm, i, got_q[i], init_exp[i]);
            end
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk_core);
      #1;
      total++;
      if (bus_if.busy_lcd !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", bus_if.busy_lcd); end
      total++;
      if ({lcd_e, lcd_rs, lcd_rw} !== 3'b000) begin
         bad++; $display("FAIL rst_ctrl e_rs_rw got=%b exp=000", {lcd_e, lcd_rs, lcd_rw});
      end
      total++;
      if (lcd_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", lcd_data); end
      test_init_seq("power_on");
   endtask

   task automatic test_char();
      int bn, er;
      model_byte(8'h41);
      send_byte(8'h41, 1'b0, bn, er);
      total++;
      if (bn != exp_busy) begin bad++; $display("FAIL char busy got=%0d exp=%0d", bn, exp_busy); end
      total++;
      if (er != exp_erise) begin bad++; $display("FAIL char e_rise got=%0d exp=%0d", er, exp_erise); end
      total++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
         bad++;
         $display("FAIL char pulse got_n=%0d got0=%h exp=%h", got_q.size(),
                  (got_q.size() > 0) ? got_q[0] : 9'h0, exp_q[0]);
      end
   endtask

   task automatic run_list(input string nm, input logic [7:0] seq[$]);
      int bn, er;
      foreach (seq[k]) begin
         model_byte(seq[k]);
         send_byte(seq[k], 1'b0, bn, er);
         total++;
         if (bn != exp_busy) begin
            bad++; $display("FAIL %s busy byte=%h got=%0d exp=%0d", nm, seq[k], bn, exp_busy);
         end
         total++;
         if (er != exp_erise) begin
            bad++; $display("FAIL %s e_rise byte=%h got=%0d exp=%0d", nm, seq[k], er, exp_erise);
         end
         total++;
         if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s pulse_count byte=%h got=%0d exp=%0d", nm, seq[k], got_q.size(), exp_q.size());
         end else begin
            foreach (exp_q[i]) begin
               total++;
               if (got_q[i] !== exp_q[i]) begin
                  bad++;
                  $display("FAIL %s pulse byte=%h idx=%0d got=%h exp=%h", nm, seq[k], i, got_q[i], exp_q[i]);
               end
            end
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] seq[$];
      int start_col = m_col;
      // Top up the current line to 16 columns, then one more byte wraps.
      for (int i = 0; i < 16 - start_col; i++) seq.push_back(8'h30 + 8'(i));
      seq.push_back(8'h58);
      run_list("wrap", seq);
   endtask

   task automatic test_ctrl();
      logic [7:0] seq[$];
      seq = '{8'h0A, 8'h0C, 8'h41, 8'h0D, 8'h42};
      run_list("ctrl", seq);
   endtask

   task automatic test_drop_ignore();
      int bn, er;
      logic [7:0] seq[$];
      seq = '{8'h07};
      run_list("drop", seq);
      model_byte(8'h42);
      send_byte(8'h42, 1'b1, bn, er);
      repeat (6) @(posedge clk_core);
      #1;
      total++;
      if (bn != exp_busy) begin bad++; $display("FAIL ignore busy got=%0d exp=%0d", bn, exp_busy); end
      total++;
      if (bus_if.busy_lcd !== 1'b0) begin
         bad++; $display("FAIL ignore late_busy got=%b exp=0", bus_if.busy_lcd);
      end
      total++;
      if (got_q.size() != 1 || got_q[0] !== {1'b1, 8'h42}) begin
         bad++;
         $display("FAIL ignore pulses got_n=%0d got0=%h exp=142", got_q.size(),
                  (got_q.size() > 0) ? got_q[0] : 9'h0);
      end
   endtask

   task automatic test_random();
      logic [7:0] seq[$];
      for (int i = 0; i < 60; i++) begin
         int r = $urandom_range(0, 9);
         if (r == 0)      seq.push_back(8'h0A);
         else if (r == 1) seq.push_back(($urandom_range(0, 1) == 1) ? 8'h0C : 8'h0D);
         else if (r == 2) seq.push_back(8'($urandom_range(0, 31)));
         else             seq.push_back(8'($urandom_range(32, 255)));
      end
      run_list("random", seq);
      total++;
      if (stab_err != 0) begin bad++; $display("FAIL bus_stability got=%0d exp=0", stab_err); end
      total++;
      if (width_err != 0) begin bad++; $display("FAIL e_width got=%0d exp=0", width_err); end
   endtask

   task automatic test_reset_midxfer();
      int guard = 0;
      while (bus_if.busy_lcd !== 1'b0 && guard < 5000) begin @(posedge clk_core); #1; guard++; end
      bus_if.bus_lcd  = 8'h55;
      bus_if.send_lcd = 1'b1;
      @(posedge clk_core); #1;
      bus_if.send_lcd = 1'b0;
      guard = 0;
      while (lcd_e !== 1'b1 && guard < 50) begin @(posedge clk_core); #1; guard++; end
      total++;
      if (lcd_e !== 1'b1) begin bad++; $display("FAIL midxfer e_seen got=%b exp=1", lcd_e); end
      #2;
      reset = 1'b0;
      #1;
      total++;
      if (lcd_e !== 1'b0) begin bad++; $display("FAIL midxfer e_async got=%b exp=0", lcd_e); end
      total++;
      if (bus_if.busy_lcd !== 1'b1) begin bad++; $display("FAIL midxfer busy got=%b exp=1", bus_if.busy_lcd); end
      repeat (2) @(posedge clk_core);
      #1;
      test_init_seq("replay");
      m_col  = 0;
      m_line = 0;
   endtask

   initial begin
      bus_if.bus_lcd  = 8'h00;
      bus_if.send_lcd = 1'b0;
      test_reset();
      test_char();
      test_wrap();
      test_ctrl();
      test_drop_ignore();
      test_random();
      test_reset_midxfer();
      test_char();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end
endmodule
